// File: rtl/issue_controller.sv
// Issue stage: hands decoded instructions to execute and the LSU, tracks outstanding
// memory ops in an in-order tag FIFO plus a register scoreboard, and owns trap/WFI sequencing.
module issue_controller #(
    parameter int MAX_OUT = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dec_valid,
    input  logic       dec_legal,
    input  logic       dec_wren,
    input  logic [4:0] dec_waddr,
    input  logic       dec_rden1,
    input  logic [4:0] dec_raddr1,
    input  logic       dec_rden2,
    input  logic [4:0] dec_raddr2,
    input  logic       dec_load,
    input  logic       dec_store,
    input  logic       dec_csr,
    input  logic       dec_fence,
    input  logic       dec_ecall,
    input  logic       dec_ebreak,
    input  logic       dec_mret,
    input  logic       dec_wfi,
    input  logic       mem_ready,
    input  logic       mem_rvalid,
    input  logic       irq_pending,
    output logic       dec_ready,
    output logic       issue,
    output logic       mem_req,
    output logic       trap_req,
    output logic [1:0] trap_cause,
    output logic       flush,
    output logic       sleeping,
    output logic [1:0] dbg_state
);

    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        TRAP  = 2'd1,
        SLEEP = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [31:0]        sb, sb_eff, sb_nxt, clr_mask, set_mask;
    logic [5:0]         fifo_q [MAX_OUT];
    logic [5:0]         head;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [1:0]         cause_q, cause_nxt;
    logic               pop, push, hazard, slot_free, can_go;
    logic               is_exc, is_serial, is_mem;
    logic               dec_ready_c, issue_c, trap_req_c, flush_c, sleeping_c;

    // A completion in the same cycle releases its destination immediately (bypass).
    assign pop      = mem_rvalid & (count != '0);
    assign head     = fifo_q[rd_ptr];
    assign clr_mask = (pop && head[5]) ? (32'd1 << head[4:0]) : 32'd0;
    assign sb_eff   = sb & ~clr_mask;

    assign hazard = (dec_rden1 & sb_eff[dec_raddr1]) |
                    (dec_rden2 & sb_eff[dec_raddr2]) |
                    (dec_wren  & sb_eff[dec_waddr]);

    assign slot_free = (count < MAX_CNT) | pop;
    assign is_exc    = ~dec_legal | dec_ecall | dec_ebreak;
    assign is_serial = is_exc | dec_csr | dec_fence | dec_mret | dec_wfi;
    assign is_mem    = dec_load | dec_store;

    always_comb begin
        can_go = 1'b0;
        if (is_serial)   can_go = (count == '0) & ~hazard;
        else if (is_mem) can_go = ~hazard & slot_free & mem_ready;
        else             can_go = ~hazard;
    end

    // Handshake: an instruction is consumed in any cycle where dec_valid & dec_ready;
    // the decoder must hold it stable until then. dec_ready is 0 whenever dec_valid is 0.
    always_comb begin
        state_nxt   = state;
        cause_nxt   = cause_q;
        dec_ready_c = 1'b0;
        issue_c     = 1'b0;
        trap_req_c  = 1'b0;
        flush_c     = 1'b0;
        sleeping_c  = 1'b0;
        case (state)
            RUN: begin
                if (dec_valid && can_go) begin
                    dec_ready_c = 1'b1;
                    if (is_exc) begin
                        state_nxt = TRAP;
                        if (!dec_legal)     cause_nxt = 2'd0;
                        else if (dec_ecall) cause_nxt = 2'd1;
                        else                cause_nxt = 2'd2;
                    end else begin
                        issue_c = 1'b1;
                        flush_c = dec_mret | dec_fence;
                        if (dec_wfi) state_nxt = SLEEP;
                    end
                end
            end
            TRAP: begin
                trap_req_c = 1'b1;
                flush_c    = 1'b1;
                state_nxt  = RUN;
            end
            SLEEP: begin
                sleeping_c = 1'b1;
                if (irq_pending) begin
                    flush_c   = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign dec_ready  = dec_ready_c & ~reset;
    assign issue      = issue_c & ~reset;
    assign mem_req    = issue & is_mem;
    assign trap_req   = trap_req_c & ~reset;
    assign trap_cause = trap_req ? cause_q : 2'd0;
    assign flush      = flush_c & ~reset;
    assign sleeping   = sleeping_c & ~reset;
    assign dbg_state  = state;

    // Stores occupy a slot with a null tag so completions stay in order.
    assign push     = issue & is_mem;
    assign set_mask = (push && dec_load && dec_wren && dec_waddr != 5'd0) ?
                      (32'd1 << dec_waddr) : 32'd0;
    assign sb_nxt   = (sb & ~clr_mask) | set_mask;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RUN;
            cause_q <= 2'd0;
            sb      <= 32'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            for (int i = 0; i < MAX_OUT; i++) fifo_q[i] <= 6'd0;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            sb      <= sb_nxt;
            if (push) begin
                fifo_q[wr_ptr] <= dec_load ? {dec_wren, dec_waddr} : 6'd0;
                wr_ptr         <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && mem_rvalid) assert (count != '0);
    end

endmodule

// File: tb/tb_issue_controller.sv
// Bench for issue_controller: a per-cycle vector table whose expected outputs are queued
// when each vector is driven and checked against the DUT on the following falling edge.
module tb_issue_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dec_valid = 1'b0, dec_legal = 1'b1, dec_wren = 1'b0;
    logic [4:0] dec_waddr = '0, dec_raddr1 = '0, dec_raddr2 = '0;
    logic       dec_rden1 = 1'b0, dec_rden2 = 1'b0;
    logic       dec_load = 1'b0, dec_store = 1'b0, dec_csr = 1'b0, dec_fence = 1'b0;
    logic       dec_ecall = 1'b0, dec_ebreak = 1'b0, dec_mret = 1'b0, dec_wfi = 1'b0;
    logic       mem_ready = 1'b0, mem_rvalid = 1'b0, irq_pending = 1'b0;
    logic       dec_ready, issue, mem_req, trap_req, flush, sleeping;
    logic [1:0] trap_cause, dbg_state;

    issue_controller #(.MAX_OUT(2)) dut (
        .clock(clock), .reset(reset),
        .dec_valid(dec_valid), .dec_legal(dec_legal),
        .dec_wren(dec_wren), .dec_waddr(dec_waddr),
        .dec_rden1(dec_rden1), .dec_raddr1(dec_raddr1),
        .dec_rden2(dec_rden2), .dec_raddr2(dec_raddr2),
        .dec_load(dec_load), .dec_store(dec_store), .dec_csr(dec_csr), .dec_fence(dec_fence),
        .dec_ecall(dec_ecall), .dec_ebreak(dec_ebreak), .dec_mret(dec_mret), .dec_wfi(dec_wfi),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .irq_pending(irq_pending),
        .dec_ready(dec_ready), .issue(issue), .mem_req(mem_req), .trap_req(trap_req),
        .trap_cause(trap_cause), .flush(flush), .sleeping(sleeping), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    // class flags {load, store, csr, fence, ecall, ebreak, mret, wfi}
    localparam logic [7:0] C_ALU = 8'h00, C_LOAD = 8'h80, C_STORE = 8'h40, C_CSR = 8'h20;
    localparam logic [7:0] C_FENCE = 8'h10, C_ECALL = 8'h08, C_EBREAK = 8'h04;
    localparam logic [7:0] C_MRET = 8'h02, C_WFI = 8'h01;
    // environment {mem_ready, mem_rvalid, irq_pending}
    localparam logic [2:0] MR = 3'b100, RV = 3'b010, IRQ = 3'b001;
    // expected outputs {dec_ready, issue, mem_req, trap_req, trap_cause[1:0], flush, sleeping}
    localparam logic [7:0] E_NONE = 8'h00, E_ISSUE = 8'hC0, E_MEM = 8'hE0, E_CONS = 8'h80;
    localparam logic [7:0] E_FLISS = 8'hC2, E_SLEEP = 8'h01, E_WAKE = 8'h03;
    localparam logic [7:0] E_TRAP_ILL = 8'h12, E_TRAP_ECALL = 8'h16, E_TRAP_EBRK = 8'h1A;

    typedef struct {
        string      name;
        logic       rst;
        logic       valid;
        logic       legal;
        logic [7:0] cls;
        logic       wren;
        logic [4:0] waddr;
        logic       rden1;
        logic [4:0] raddr1;
        logic       rden2;
        logic [4:0] raddr2;
        logic [2:0] env;
        logic [7:0] exp;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_compared = 0;
    int         n_mismatch = 0;

    function automatic vec_t ins(string nm, logic [7:0] cls, int rd, int rs1, int rs2,
                                 logic [2:0] env, logic [7:0] exp);
        vec_t v;
        v.name = nm;     v.rst = 1'b0;   v.valid = 1'b1; v.legal = 1'b1;
        v.cls = cls;     v.env = env;    v.exp = exp;
        v.wren = (rd != 0);   v.waddr  = 5'(rd);
        v.rden1 = (rs1 != 0); v.raddr1 = 5'(rs1);
        v.rden2 = (rs2 != 0); v.raddr2 = 5'(rs2);
        return v;
    endfunction

    function automatic vec_t idle(string nm, logic [2:0] env, logic [7:0] exp);
        vec_t v = ins(nm, C_ALU, 0, 0, 0, env, exp);
        v.valid = 1'b0;
        return v;
    endfunction

    // driver
    task automatic drive(input vec_t v);
        reset      = v.rst;
        dec_valid  = v.valid;
        dec_legal  = v.legal;
        {dec_load, dec_store, dec_csr, dec_fence, dec_ecall, dec_ebreak, dec_mret, dec_wfi} = v.cls;
        dec_wren   = v.wren;  dec_waddr  = v.waddr;
        dec_rden1  = v.rden1; dec_raddr1 = v.raddr1;
        dec_rden2  = v.rden2; dec_raddr2 = v.raddr2;
        {mem_ready, mem_rvalid, irq_pending} = v.env;
        exp_q.push_back(v.exp);
        name_q.push_back(v.name);
    endtask

    // scoreboard
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            logic [7:0] got, exp;
            string      nm;
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {dec_ready, issue, mem_req, trap_req, trap_cause, flush, sleeping};
            n_compared++;
            if (got !== exp) begin
                n_mismatch++;
                $display("FAIL %s: got %b expected %b (rdy,iss,mreq,trap,cause,flush,sleep)",
                         nm, got, exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        // reset and plain issue
        t = ins("reset_quiet", C_ALU, 1, 2, 3, MR, E_NONE); t.rst = 1'b1; tbl.push_back(t);
        tbl.push_back(ins("plain_issue", C_ALU, 6, 2, 3, MR, E_ISSUE));
        tbl.push_back(idle("idle_no_valid", MR, E_NONE));
        // load-use hazard with same-cycle bypass
        tbl.push_back(ins("load_x5", C_LOAD, 5, 1, 0, MR, E_MEM));
        tbl.push_back(ins("raw_rs1_stall", C_ALU, 6, 5, 1, MR, E_NONE));
        tbl.push_back(ins("raw_bypass_issue", C_ALU, 6, 5, 1, MR | RV, E_ISSUE));
        // WAW and rs2 hazards
        tbl.push_back(ins("load_x8", C_LOAD, 8, 1, 0, MR, E_MEM));
        tbl.push_back(ins("waw_stall", C_ALU, 8, 1, 2, MR, E_NONE));
        tbl.push_back(ins("waw_bypass_issue", C_ALU, 8, 1, 2, MR | RV, E_ISSUE));
        tbl.push_back(ins("load_x9", C_LOAD, 9, 1, 0, MR, E_MEM));
        tbl.push_back(ins("raw_rs2_stall", C_ALU, 10, 1, 9, MR, E_NONE));
        tbl.push_back(idle("drain_x9", MR | RV, E_NONE));
        tbl.push_back(ins("raw_rs2_clear", C_ALU, 10, 1, 9, MR, E_ISSUE));
        // LSU back-pressure
        tbl.push_back(ins("load_not_ready", C_LOAD, 5, 1, 0, 3'b000, E_NONE));
        tbl.push_back(ins("plain_not_ready", C_ALU, 3, 1, 2, 3'b000, E_ISSUE));
        // outstanding limit with stores
        tbl.push_back(ins("store_1", C_STORE, 0, 1, 2, MR, E_MEM));
        tbl.push_back(ins("store_2", C_STORE, 0, 1, 2, MR, E_MEM));
        tbl.push_back(ins("store_3_full", C_STORE, 0, 1, 2, MR, E_NONE));
        tbl.push_back(ins("store_3_bypass", C_STORE, 0, 1, 2, MR | RV, E_MEM));
        tbl.push_back(ins("plain_while_full", C_ALU, 3, 1, 2, MR, E_ISSUE));
        tbl.push_back(idle("drain_a", MR | RV, E_NONE));
        tbl.push_back(idle("drain_b", MR | RV, E_NONE));
        // push and pop of the same destination: set wins
        tbl.push_back(ins("load_x5_again", C_LOAD, 5, 1, 0, MR, E_MEM));
        tbl.push_back(ins("load_x5_swap", C_LOAD, 5, 1, 0, MR | RV, E_MEM));
        tbl.push_back(ins("set_wins_stall", C_ALU, 6, 5, 0, MR, E_NONE));
        tbl.push_back(ins("set_wins_release", C_ALU, 6, 5, 0, MR | RV, E_ISSUE));
        // csr serialisation
        tbl.push_back(ins("load_x7", C_LOAD, 7, 1, 0, MR, E_MEM));
        tbl.push_back(ins("csr_held", C_CSR, 11, 2, 0, MR, E_NONE));
        tbl.push_back(ins("csr_held_rvalid", C_CSR, 11, 2, 0, MR | RV, E_NONE));
        tbl.push_back(ins("csr_issue", C_CSR, 11, 2, 0, MR, E_ISSUE));
        tbl.push_back(ins("fence_flush", C_FENCE, 0, 0, 0, MR, E_FLISS));
        tbl.push_back(ins("mret_flush", C_MRET, 0, 0, 0, MR, E_FLISS));
        // traps
        t = ins("illegal_consume", C_ALU, 0, 0, 0, MR, E_CONS); t.legal = 1'b0; tbl.push_back(t);
        tbl.push_back(ins("illegal_trap", C_ALU, 1, 2, 3, MR, E_TRAP_ILL));
        tbl.push_back(ins("after_trap", C_ALU, 1, 2, 3, MR, E_ISSUE));
        tbl.push_back(ins("ecall_consume", C_ECALL, 0, 0, 0, MR, E_CONS));
        tbl.push_back(idle("ecall_trap", MR, E_TRAP_ECALL));
        tbl.push_back(ins("ebreak_consume", C_EBREAK, 0, 0, 0, MR, E_CONS));
        tbl.push_back(idle("ebreak_trap", MR, E_TRAP_EBRK));
        // WFI sleep and wake
        tbl.push_back(ins("wfi_issue", C_WFI, 0, 0, 0, MR, E_ISSUE));
        tbl.push_back(idle("sleep_idle", MR, E_SLEEP));
        for (int i = 0; i < 3; i++)
            tbl.push_back(ins("sleep_blocks", C_ALU, 1, 2, 3, MR, E_SLEEP));
        tbl.push_back(ins("wake_flush", C_ALU, 1, 2, 3, MR | IRQ, E_WAKE));
        tbl.push_back(ins("run_after_wake", C_ALU, 1, 2, 3, MR, E_ISSUE));
        tbl.push_back(ins("wfi_irq_pending", C_WFI, 0, 0, 0, MR | IRQ, E_ISSUE));
        tbl.push_back(idle("one_sleep_cycle", MR | IRQ, E_WAKE));
        tbl.push_back(ins("run_after_wake2", C_ALU, 1, 2, 3, MR, E_ISSUE));
        // reset with loads outstanding
        tbl.push_back(ins("load_x13", C_LOAD, 13, 1, 0, MR, E_MEM));
        tbl.push_back(ins("load_x14", C_LOAD, 14, 1, 0, MR, E_MEM));
        tbl.push_back(ins("dep_stall", C_ALU, 15, 13, 14, MR, E_NONE));
        t = ins("reset_midop", C_ALU, 15, 13, 14, MR, E_NONE); t.rst = 1'b1; tbl.push_back(t);
        tbl.push_back(ins("indep_after_reset", C_ALU, 16, 1, 2, MR, E_ISSUE));
        tbl.push_back(ins("sb_cleared", C_ALU, 15, 13, 14, MR, E_ISSUE));
        tbl.push_back(ins("post_rst_store_1", C_STORE, 0, 1, 2, MR, E_MEM));
        tbl.push_back(ins("post_rst_store_2", C_STORE, 0, 1, 2, MR, E_MEM));
        tbl.push_back(ins("post_rst_full", C_STORE, 0, 1, 2, MR, E_NONE));
        tbl.push_back(idle("final_drain_a", MR | RV, E_NONE));
        tbl.push_back(idle("final_drain_b", MR | RV, E_NONE));
        tbl.push_back(ins("final_csr_empty", C_CSR, 4, 1, 0, MR, E_ISSUE));
        // randomised idle gaps: no valid means nothing is consumed or issued
        for (int i = 0; i < 4; i++)
            tbl.push_back(idle("rand_idle", {1'b1, 1'b0, 1'($urandom_range(0, 1)) & 1'b0}, E_NONE));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clock);
            #1;
            drive(tbl[i]);
        end
        @(posedge clock);
        #1;
        drive(idle("tail", 3'b000, E_NONE));
        @(negedge clock);
        #1;
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatch++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
